// File: rtl/rom_fifo_xfer_sched.sv
// Transmit-side ROM -> DCFIFO transfer scheduler (trclk domain).
// Two requesters post (base, length) descriptors. They are served round-robin.
// Each transfer reads the ROM one word at a time and pushes every word into the
// DCFIFO write port, stalling while the FIFO reports full.
module rom_fifo_xfer_sched #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int LW = 11
) (
  input  logic          trclk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [AW-1:0] base0,
  input  logic [LW-1:0] len0,
  input  logic [AW-1:0] base1,
  input  logic [LW-1:0] len1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          busy,
  output logic          active_id,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q,
  input  logic          fifo_wrfull,
  output logic          fifo_wrreq,
  output logic [DW-1:0] fifo_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state;
  logic          last;
  logic [LW-1:0] remaining;
  logic          win_id;
  logic [AW-1:0] base_sel;
  logic [LW-1:0] len_sel;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  // Arbitration winner: a sole requester wins; on a tie the one that was not served last.
  always_comb begin
    win_id = req[1];
    if (req == 2'b11) win_id = ~last;
  end

  // Descriptor of the requester chosen at arbitration time.
  always_comb begin
    base_sel = active_id ? base1 : base0;
    len_sel  = active_id ? len1  : len0;
  end

  // Control FSM. rom_addr doubles as the running word address: it is loaded
  // with the base in GRANT, held through WRITE so rom_q stays stable while
  // the FIFO is full, and advances (mod 2**AW) on each accepted write.
  always_ff @(posedge trclk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      gnt       <= 2'b00;
      done      <= 2'b00;
      busy      <= 1'b0;
      active_id <= 1'b0;
      last      <= 1'b1;
      rom_addr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state     <= S_GRANT;
            gnt       <= id_onehot(win_id);
            busy      <= 1'b1;
            active_id <= win_id;
          end
        end
        S_GRANT: begin
          gnt       <= 2'b00;
          last      <= active_id;
          rom_addr  <= base_sel;
          remaining <= len_sel;
          if (len_sel == '0) begin
            state <= S_DONE;
            done  <= id_onehot(active_id);
          end else begin
            state <= S_READ;
          end
        end
        S_READ: begin
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (!fifo_wrfull) begin
            rom_addr  <= rom_addr + AW'(1);
            remaining <= remaining - LW'(1);
            if (remaining == LW'(1)) begin
              state <= S_DONE;
              done  <= id_onehot(active_id);
            end else begin
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          done  <= 2'b00;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
          done  <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO write port: ROM data passes straight through; a write is issued
  // only in WRITE and never while the FIFO is full.
  always_comb begin
    fifo_wrreq = (state == S_WRITE) && !fifo_wrfull;
    fifo_data  = rom_q;
  end

endmodule
